// File: rtl/rtc_timekeeper.sv
// Hours/minutes/seconds timekeeper with tick prescaler, run/hold, validated load and 12/24h display.
// Time and strobes are visible one edge after the qualifying edge; no backpressure. Alarm: define RTC_ALARM_EN.
module rtc_timekeeper #(
    parameter int TICKS_PER_SEC = 1
) (
    input  logic       Clk_1sec,
    input  logic       reset,
    input  logic       run,
    input  logic       mode_12h,
    input  logic       load,
    input  logic [4:0] init_hours,
    input  logic [5:0] init_minutes,
    input  logic [5:0] init_seconds,
    output logic       load_err,
    output logic [5:0] seconds,
    output logic [5:0] minutes,
    output logic [4:0] hours,
    output logic       pm,
    output logic       day_wrap
`ifdef RTC_ALARM_EN
    ,
    input  logic       alarm_set,
    input  logic [4:0] alarm_hours,
    input  logic [5:0] alarm_minutes,
    input  logic       alarm_ack,
    output logic       alarm_ring
`endif
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PS_MAX = PW'(TICKS_PER_SEC - 1);

    logic [4:0]    hr;
    logic [5:0]    min;
    logic [5:0]    sec;
    logic [PW-1:0] presc;

    logic          tick;
    logic          load_ok;
    logic [4:0]    nxt_hr;
    logic [5:0]    nxt_min;
    logic [5:0]    nxt_sec;
    logic          nxt_wrap;

    always_comb begin
        tick     = run && (presc == PS_MAX);
        load_ok  = load && (init_hours <= 5'd23) && (init_minutes <= 6'd59)
                   && (init_seconds <= 6'd59);
        nxt_sec  = sec + 6'd1;
        nxt_min  = min;
        nxt_hr   = hr;
        nxt_wrap = 1'b0;
        if (sec == 6'd59) begin
            nxt_sec = 6'd0;
            nxt_min = min + 6'd1;
            if (min == 6'd59) begin
                nxt_min = 6'd0;
                nxt_hr  = hr + 5'd1;
                if (hr == 5'd23) begin
                    nxt_hr   = 5'd0;
                    nxt_wrap = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Clk_1sec or negedge reset) begin
        if (!reset) begin
            hr       <= 5'd0;
            min      <= 6'd0;
            sec      <= 6'd0;
            presc    <= '0;
            load_err <= 1'b0;
            day_wrap <= 1'b0;
        end else begin
            load_err <= load && !load_ok;
            day_wrap <= 1'b0;
            // A valid load wins over a coinciding tick; a rejected one lets it through.
            if (load_ok) begin
                hr    <= init_hours;
                min   <= init_minutes;
                sec   <= init_seconds;
                presc <= '0;
            end else if (run) begin
                if (tick) begin
                    presc    <= '0;
                    hr       <= nxt_hr;
                    min      <= nxt_min;
                    sec      <= nxt_sec;
                    day_wrap <= nxt_wrap;
                end else begin
                    presc <= presc + PW'(1);
                end
            end
        end
    end

    assign seconds = sec;
    assign minutes = min;

    // Display mapping only reads the registered hour, so a mode flip cannot glitch state.
    always_comb begin
        pm    = (hr >= 5'd12);
        hours = hr;
        if (mode_12h) begin
            if (hr == 5'd0)
                hours = 5'd12;
            else if (hr > 5'd12)
                hours = hr - 5'd12;
        end
    end

`ifdef RTC_ALARM_EN
    logic [4:0] al_hr;
    logic [5:0] al_min;
    logic       armed;
    logic       al_match;

    // Only tick-driven arrivals match; out-of-range alarm fields can never equal nxt_*.
    assign al_match = armed && tick && !load_ok && (nxt_hr == al_hr)
                      && (nxt_min == al_min) && (nxt_sec == 6'd0);

    always_ff @(posedge Clk_1sec or negedge reset) begin
        if (!reset) begin
            al_hr      <= 5'd0;
            al_min     <= 6'd0;
            armed      <= 1'b0;
            alarm_ring <= 1'b0;
        end else if (alarm_set) begin
            al_hr      <= alarm_hours;
            al_min     <= alarm_minutes;
            armed      <= 1'b1;
            alarm_ring <= 1'b0;
        end else if (al_match) begin
            alarm_ring <= 1'b1;
        end else if (alarm_ack) begin
            alarm_ring <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Two instances (1 and 4 ticks/second) share stimulus; a total-seconds-of-day model feeds per-instance queues.
module tb_rtc_timekeeper;

    localparam int TPS_A = 1;
    localparam int TPS_B = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run, mode_12h, load;
    logic [4:0] i_hr;
    logic [5:0] i_min, i_sec;

    logic       le1, pm1, dw1, le4, pm4, dw4;
    logic [5:0] sec1, min1, sec4, min4;
    logic [4:0] hr1, hr4;

`ifdef RTC_ALARM_EN
    logic       a_set, a_ack, ring1, ring4;
    logic [4:0] a_hr;
    logic [5:0] a_min;
`endif

    always #5 clk = ~clk;

    rtc_timekeeper #(.TICKS_PER_SEC(TPS_A)) dut1 (
        .Clk_1sec(clk), .reset(rst_n), .run(run), .mode_12h(mode_12h), .load(load),
        .init_hours(i_hr), .init_minutes(i_min), .init_seconds(i_sec),
        .load_err(le1), .seconds(sec1), .minutes(min1), .hours(hr1), .pm(pm1), .day_wrap(dw1)
`ifdef RTC_ALARM_EN
        , .alarm_set(a_set), .alarm_hours(a_hr), .alarm_minutes(a_min),
        .alarm_ack(a_ack), .alarm_ring(ring1)
`endif
    );

    rtc_timekeeper #(.TICKS_PER_SEC(TPS_B)) dut4 (
        .Clk_1sec(clk), .reset(rst_n), .run(run), .mode_12h(mode_12h), .load(load),
        .init_hours(i_hr), .init_minutes(i_min), .init_seconds(i_sec),
        .load_err(le4), .seconds(sec4), .minutes(min4), .hours(hr4), .pm(pm4), .day_wrap(dw4)
`ifdef RTC_ALARM_EN
        , .alarm_set(a_set), .alarm_hours(a_hr), .alarm_minutes(a_min),
        .alarm_ack(a_ack), .alarm_ring(ring4)
`endif
    );

    typedef struct {
        int s;
        int m;
        int h;
        int pm;
        int le;
        int dw;
    } exp_t;

    exp_t q1[$];
    exp_t q4[$];
    int   t_m[2];
    int   p_m[2];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input int t, input int le, input int dw, input bit m12);
        exp_t e;
        int   h24;
        h24  = t / 3600;
        e.s  = t % 60;
        e.m  = (t / 60) % 60;
        e.h  = m12 ? ((h24 % 12 == 0) ? 12 : h24 % 12) : h24;
        e.pm = (h24 >= 12) ? 1 : 0;
        e.le = le;
        e.dw = dw;
        return e;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            t_m[d] = 0;
            p_m[d] = 0;
        end
    endtask

    // Called once per cycle after inputs are driven; predicts what the next edge shows.
    task automatic model_step();
        bit   ok;
        int   le, dw, n;
        exp_t e;
        ok = load && (int'(i_hr) < 24) && (int'(i_min) < 60) && (int'(i_sec) < 60);
        for (int d = 0; d < 2; d++) begin
            n  = (d == 0) ? TPS_A : TPS_B;
            le = (load && !ok) ? 1 : 0;
            dw = 0;
            if (ok) begin
                t_m[d] = int'(i_hr) * 3600 + int'(i_min) * 60 + int'(i_sec);
                p_m[d] = 0;
            end else if (run) begin
                if (p_m[d] == n - 1) begin
                    p_m[d] = 0;
                    t_m[d] = (t_m[d] + 1) % 86400;
                    dw     = (t_m[d] == 0) ? 1 : 0;
                end else begin
                    p_m[d]++;
                end
            end
            e = mk(t_m[d], le, dw, mode_12h);
            if (d == 0) q1.push_back(e);
            else        q4.push_back(e);
        end
    endtask

    task automatic cyc(input bit r, input bit md, input bit ld, input int h, input int m, input int s);
        @(negedge clk);
        run      = r;
        mode_12h = md;
        load     = ld;
        i_hr     = 5'(h);
        i_min    = 6'(m);
        i_sec    = 6'(s);
`ifdef RTC_ALARM_EN
        a_set = 1'b0;
        a_ack = 1'b0;
`endif
        model_step();
    endtask

`ifdef RTC_ALARM_EN
    task automatic acyc(input bit r, input bit ld, input int h, input int m, input int s,
                        input bit st, input bit ack, input int ah, input int am);
        @(negedge clk);
        run      = r;
        mode_12h = 1'b0;
        load     = ld;
        i_hr     = 5'(h);
        i_min    = 6'(m);
        i_sec    = 6'(s);
        a_set    = st;
        a_ack    = ack;
        a_hr     = 5'(ah);
        a_min    = 6'(am);
        model_step();
    endtask
`endif

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    // Monitor: outputs are valid every cycle, so each queued prediction is consumed one edge later.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q1.size() > 0) begin
                e = q1.pop_front();
                chk("d1.seconds", sec1, e.s);
                chk("d1.minutes", min1, e.m);
                chk("d1.hours", hr1, e.h);
                chk("d1.pm", pm1, e.pm);
                chk("d1.load_err", le1, e.le);
                chk("d1.day_wrap", dw1, e.dw);
            end
            if (q4.size() > 0) begin
                e = q4.pop_front();
                chk("d4.seconds", sec4, e.s);
                chk("d4.minutes", min4, e.m);
                chk("d4.hours", hr4, e.h);
                chk("d4.pm", pm4, e.pm);
                chk("d4.load_err", le4, e.le);
                chk("d4.day_wrap", dw4, e.dw);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int h, m, s;
        rst_n    = 1'b0;
        run      = 1'b0;
        mode_12h = 1'b0;
        load     = 1'b0;
        i_hr     = '0;
        i_min    = '0;
        i_sec    = '0;
`ifdef RTC_ALARM_EN
        a_set = 1'b0;
        a_ack = 1'b0;
        a_hr  = '0;
        a_min = '0;
`endif
        model_reset();
        #12;
        chk("rst.seconds", sec1, 0);
        chk("rst.minutes", min1, 0);
        chk("rst.hours24", hr1, 0);
        chk("rst.pm", pm1, 0);
        chk("rst.load_err", le1, 0);
        chk("rst.day_wrap", dw1, 0);
        mode_12h = 1'b1;
        #1;
        chk("rst.hours12", hr1, 12);
        chk("rst.hours12_d4", hr4, 12);
        mode_12h = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // 02:52:00 plus 120 one-second ticks
        cyc(1, 0, 1, 2, 52, 0);
        repeat (120) cyc(1, 0, 0, 0, 0, 0);
        after_edge();
        chk("run120.seconds", sec1, 0);
        chk("run120.minutes", min1, 54);
        chk("run120.hours", hr1, 2);

        // Day rollover in 12-hour mode
        cyc(1, 1, 1, 23, 59, 58);
        cyc(1, 1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0);
        after_edge();
        chk("wrap.hours12", hr1, 12);
        chk("wrap.pm", pm1, 0);
        chk("wrap.day_wrap", dw1, 1);
        chk("wrap.seconds", sec1, 0);
        cyc(1, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);

        // Prescaler hold/resume on the 4-tick instance
        cyc(1, 0, 1, 0, 0, 0);
        repeat (4) cyc(1, 0, 0, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 0, 0, 0);
        repeat (4) cyc(1, 0, 0, 0, 0, 0);
        after_edge();
        chk("hold.d4.seconds", sec4, 2);

        // Rejected loads, then a valid load on a tick edge
        cyc(0, 0, 1, 10, 20, 30);
        cyc(0, 0, 1, 24, 0, 0);
        cyc(0, 0, 1, 10, 60, 0);
        cyc(0, 0, 1, 1, 2, 60);
        cyc(1, 0, 1, 31, 0, 0);
        cyc(1, 0, 1, 5, 6, 7);
        after_edge();
        chk("tickload.seconds", sec1, 7);
        chk("tickload.load_err", le1, 0);
        cyc(0, 0, 0, 0, 0, 0);

        // Display mode toggles at 13:05:00 and 00:00:00
        cyc(0, 0, 1, 13, 5, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        after_edge();
        chk("m12.hours", hr1, 1);
        chk("m12.pm", pm1, 1);
        cyc(0, 1, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);

`ifdef RTC_ALARM_EN
        acyc(0, 0, 0, 0, 0, 1, 0, 7, 30);
        acyc(1, 1, 7, 29, 58, 0, 0, 0, 0);
        acyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        acyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        after_edge();
        chk("alarm.ring", ring1, 1);
        acyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
        after_edge();
        chk("alarm.ack", ring1, 0);
        acyc(0, 0, 0, 0, 0, 1, 0, 7, 30);
        acyc(1, 1, 7, 30, 0, 0, 0, 0, 0);
        acyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        after_edge();
        chk("alarm.load_no_ring", ring1, 0);
`endif

        // Randomised traffic
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                h = 23;
                m = 59;
                s = $urandom_range(50, 59);
            end else begin
                h = $urandom_range(0, 25);
                m = $urandom_range(0, 61);
                s = $urandom_range(0, 61);
            end
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 7) == 0, h, m, s);
        end

        // Asynchronous reset in the middle of counting
        cyc(1, 0, 1, 14, 33, 21);
        repeat (3) cyc(1, 0, 0, 0, 0, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.seconds", sec1, 0);
        chk("arst.minutes", min1, 0);
        chk("arst.hours", hr1, 0);
        chk("arst.d4.seconds", sec4, 0);
        chk("arst.d4.minutes", min4, 0);
        chk("arst.d4.hours", hr4, 0);
        @(negedge clk);
        run   = 1'b0;
        rst_n = 1'b1;
        model_reset();
        repeat (5) cyc(1, 0, 0, 0, 0, 0);

        repeat (2) after_edge();
        chk("scoreboard.drained", q1.size() + q4.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rtc_timekeeper.md
# rtc_timekeeper

Parametrised hours/minutes/seconds timekeeper, the successor to the fixed 1 Hz digital clock. It adds a tick prescaler, a run/hold control, a validated load port, 12/24-hour display mode, a day-rollover strobe and an optional alarm. It sits between the clock source and the display/BCD formatting logic and is the single owner of current time.

## Interface
- TICKS_PER_SEC, default 1: Clk_1sec edges per second; 1 means every edge is one second; legal range 1..2^24.
- Clk_1sec  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- run  input  1  1 = time advances; 0 = hold (prescaler frozen).
- mode_12h  input  1  0 = 24-hour display, 1 = 12-hour display; affects outputs only.
- load  input  1  single-cycle load strobe.
- init_hours  input  5  load value, 0..23 (always 24-hour).
- init_minutes  input  6  load value, 0..59.
- init_seconds  input  6  load value, 0..59.
- load_err  output  1  one-cycle pulse: load rejected (out-of-range field).
- seconds  output  6  current seconds 0..59.
- minutes  output  6  current minutes 0..59.
- hours  output  5  display hours: 0..23, or 1..12 in 12-hour mode.
- pm  output  1  1 when internal hour is 12..23 (valid in both modes).
- day_wrap  output  1  one-cycle pulse on 23:59:59 -> 00:00:00.
- alarm_set  input  1  latch alarm_hours/alarm_minutes and arm (RTC_ALARM_EN only).
- alarm_hours  input  5  alarm hour 0..23 (RTC_ALARM_EN only).
- alarm_minutes  input  6  alarm minute 0..59 (RTC_ALARM_EN only).
- alarm_ack  input  1  clears alarm_ring (RTC_ALARM_EN only).
- alarm_ring  output  1  level, set at alarm match (RTC_ALARM_EN only).

## Operation
- Internal state: hr 0..23, min, sec, prescaler 0..TICKS_PER_SEC-1, width $clog2(TICKS_PER_SEC) (minimum 1 bit).
- Reset: hr/min/sec/prescaler = 0; outputs 00:00:00; hours = 12 in 12-hour mode; pm = 0; load_err, day_wrap, alarm_ring = 0; alarm disarmed, alarm registers = 0.
- Tick: when run = 1 and prescaler == TICKS_PER_SEC-1, prescaler -> 0 and time advances one second; otherwise, with run = 1, prescaler increments.
- Carry chain: sec 59 -> 0 carries min; min 59 -> 0 carries hr; hr 23 -> 0 with day_wrap pulse in the same cycle the outputs show 00:00:00.
- Load: if all three fields are in range, time = init values and prescaler = 0 on that edge. Otherwise, state is unchanged and load_err pulses the next cycle.
- Priority: load > tick. A valid load in a tick cycle discards that tick. A rejected load does not block the tick.
- 12-hour mapping: hr 0 -> 12, 1..12 -> same, 13..23 -> hr-12. This mapping is combinational from registered hr and is glitch-free across mode_12h changes.

## Timing
- Outputs are registered; the time change is visible the cycle after the qualifying edge.
- TICKS_PER_SEC = 1 with run = 1: seconds advances every cycle.
- run deasserted mid-second keeps the prescaler value; the second completes after the remaining edges once run returns.
- Reset asserted mid-operation clears all state immediately (async). Deassertion is synchronised by the integrator.
- Alarm match: on a tick whose new time is alarm_hours:alarm_minutes:00 while armed -> alarm_ring = 1 the same cycle as the new time.
- A load onto the alarm time never fires the alarm.
- alarm_ack clears alarm_ring next edge; ack coincident with a new match leaves alarm_ring = 1.
- alarm_set re-arms and clears alarm_ring. Out-of-range alarm values are latched but never match.

## Configuration
- RTC_ALARM_EN defined: alarm registers, ports and match logic are present.
- RTC_ALARM_EN undefined: alarm ports are absent and no alarm logic is synthesised. All other behaviour is identical.

## Test plan
- TICKS_PER_SEC = 1: reset, load 02:52:00, run 120 cycles -> reads 02:54:00; no load_err, no day_wrap.
- Load 23:59:58, run -> 23:59:59, then 00:00:00 with day_wrap high exactly one cycle; hours = 12, pm = 0 in 12-hour mode.
- TICKS_PER_SEC = 4: run 4 edges, drop run for 3 edges, restore -> seconds increments on edge 4 only, then 4 edges later. The hold does not shift the count.
- Load 24:00:00 and 10:60:00 -> each gives a load_err pulse, time unchanged. Load on a tick edge with 05:06:07 -> shows 05:06:07, tick dropped.
- Alarm: set 07:30, load 07:29:58 -> alarm_ring rises at 07:30:00. Ack -> clears. Load 07:30:00 directly -> no ring.
- mode_12h toggled at 13:05:00 -> hours 13 -> 1, pm = 1. At 00:00:00 -> hours 12, pm = 0. Assert reset mid-count -> all outputs 0 immediately.
